iob_copy_master: RTL
====================

Name: iob_copy_master

Overview:
- Native-bus initiator: copies a block of 32-bit words from a source address to a destination address by issuing read and write transactions on an iob master port.
- Its master port connects to a slave port of a dbus/pbus split, in the same position as the CPU data bus, so it drives the same valid/address/wdata/wstrb and consumes the same rdata/ready that peripherals answer.
- It is configured by a start pulse with source, destination and length inputs, and reports busy and done.

Parameters:
- ADDR_W, 32, byte address width of master port and src/dst inputs
- DATA_W, 32, data width; wstrb width is DATA_W/8
- LEN_W, 16, width of word-count input and internal counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset; all state is cleared on a clk edge with rst=0
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE
- src_addr  input  ADDR_W  source byte address; word-aligned, bits[1:0] ignored
- dst_addr  input  ADDR_W  destination byte address; word-aligned, bits[1:0] ignored
- len  input  LEN_W  number of words to copy
- busy  output  1  copy in progress
- done  output  1  one-cycle pulse when the copy completes
- m_valid  output  1  request valid; held until m_ready
- m_address  output  ADDR_W  request byte address
- m_wdata  output  DATA_W  write data
- m_wstrb  output  DATA_W/8  byte enables; 0 means read
- m_rdata  input  DATA_W  read data, valid in the m_ready cycle of a read
- m_ready  input  1  one-cycle response completing the current request

Behaviour:
- Reset (rst=0): state IDLE; busy=0, done=0, m_valid=0, m_address=0, m_wdata=0, m_wstrb=0; counters and data buffer cleared.
- Reset mid-copy aborts immediately; the next cycle shows reset values and no further requests are issued.
- FSM states: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE.
- IDLE, start=1, len!=0: latch src, dst and len (bits[1:0] of both addresses forced to 0); go to RD_REQ; busy=1 from the next cycle.
- IDLE, start=1, len=0: go to DONE with no bus traffic.
- start is ignored in every state except IDLE.
- RD_REQ: m_valid=1, m_wstrb=0, m_address=src_ptr.
  - Held stable until m_ready=1.
  - In the m_ready cycle, capture m_rdata into the buffer and go to RD_GAP.
- RD_GAP: m_valid=0 for exactly one cycle, then WR_REQ.
- WR_REQ: m_valid=1, m_wstrb=all ones, m_address=dst_ptr, m_wdata=buffer.
  - Held stable until m_ready=1.
  - In the m_ready cycle: decrement the remaining count; src_ptr+=4 and dst_ptr+=4, modulo 2^ADDR_W (wrap-around permitted, no error).
  - Then go to WR_GAP.
- WR_GAP: m_valid=0 for one cycle; then RD_REQ if remaining!=0, else DONE.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE. A start in the DONE cycle is ignored.
- m_ready while m_valid=0 (a gap or IDLE) is ignored.
- Request signals are registered outputs and must not change while m_valid=1 and m_ready=0.
- Minimum cycles per word: 4 plus slave latencies. With single-cycle-ready slaves a word takes 4 cycles: RD_REQ, RD_GAP, WR_REQ, WR_GAP.
- Total latency with 1-cycle slaves: start cycle + 4*len + 1 DONE cycle.
- len=2^LEN_W-1 must complete with no counter overflow.
- Only one transaction is outstanding at any time.

Test Plan:
- Copy 3 words, src=0x100, dst=0x200, slave ready 1 cycle after valid, memory[0x100..0x108]={0xA,0xB,0xC}:
  - required bus sequence: R100, W200=A, R104, W204=B, R108, W208=C;
  - m_wstrb is 0 on reads and 0xF on writes;
  - done pulses once 13 cycles after start;
  - busy is high in between.
- len=0 start -> no m_valid ever asserts; done=1 on the next cycle; busy stays 0.
- Variable slave latency, ready delayed 0-5 random cycles -> address/wdata/wstrb stable throughout each valid window; data copied correctly for len=16.
- src=0xFFFFFFFC, dst=0x10, len=2 -> reads at 0xFFFFFFFC then 0x00000000; writes at 0x10 then 0x14.
- Assert rst=0 during the second WR_REQ of a len=4 copy -> the next cycle shows m_valid=0, busy=0, done=0; no further requests; a fresh start after reset runs normally.
- Pulse start while busy and in the DONE cycle -> ignored: no extra transactions, exactly one done pulse per accepted start; unaligned src=0x103 is treated as 0x100.

Source files
------------

// File: rtl/iob_copy_master.sv
// iob_copy_master: native-bus block copy initiator.
// Copies len 32-bit words from src_addr to dst_addr, one read then one write
// per word, with a one-cycle idle gap after every transaction.
module iob_copy_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_GAP,
    WR_REQ,
    WR_GAP,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

  // Next-state, datapath updates and next values of the registered bus outputs.
  // Bus outputs are derived from the next state so they are registered yet
  // line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src_addr & ~ADDR_W'(3);
            dst_d   = dst_addr & ~ADDR_W'(3);
            rem_d   = len;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_REQ: begin
        if (m_ready) begin
          buf_d   = m_rdata;
          state_d = RD_GAP;
        end
      end
      RD_GAP: state_d = WR_REQ;
      WR_REQ: begin
        if (m_ready) begin
          rem_d   = rem_q - LEN_W'(1);
          src_d   = src_q + ADDR_W'(4);
          dst_d   = dst_q + ADDR_W'(4);
          state_d = WR_GAP;
        end
      end
      WR_GAP: state_d = (rem_q != '0) ? RD_REQ : DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
    busy_d  = (state_d == RD_REQ) || (state_d == RD_GAP) ||
              (state_d == WR_REQ) || (state_d == WR_GAP);
    done_d  = (state_d == DONE);
    addr_d  = '0;
    wdata_d = '0;
    wstrb_d = '0;
    if (state_d == RD_REQ) begin
      addr_d = src_d;
    end else if (state_d == WR_REQ) begin
      addr_d  = dst_d;
      wdata_d = buf_d;
      wstrb_d = '1;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign m_valid   = valid_q;
  assign m_address = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;

endmodule
